// File: rtl/vga_rect_fill_engine.sv
// Rectangle fill master: clips one rectangle command to the visible area and
// writes it pixel by pixel in raster order, stalling on src_rdy.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for a command, cmd_ready high
// S_CLIP  | one cycle: compute clamped end corner, detect empty command
// S_WRITE | issuing pixel writes, advancing on src_write & src_rdy
// S_DONE  | one cycle: done pulse, clipped valid
module vga_rect_fill_engine #(
    parameter int H_SIZE    = 10,
    parameter int V_SIZE    = 10,
    parameter int H_DISPLAY = 640,
    parameter int V_DISPLAY = 480,
    parameter int RGB_SIZE  = 12,
    parameter int AVS_DW    = 16
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [H_SIZE-1:0]   cmd_x0,
    input  logic [V_SIZE-1:0]   cmd_y0,
    input  logic [H_SIZE-1:0]   cmd_w,
    input  logic [V_SIZE-1:0]   cmd_h,
    input  logic [RGB_SIZE-1:0] cmd_color,
    output logic                busy,
    output logic                done,
    output logic                clipped,
    output logic                src_read,
    output logic                src_write,
    output logic [H_SIZE-1:0]   src_x,
    output logic [V_SIZE-1:0]   src_y,
    output logic [AVS_DW-1:0]   src_writedata,
    input  logic                src_rdy
);

    localparam int XW = H_SIZE + 1;
    localparam int YW = V_SIZE + 1;
    localparam logic [XW-1:0] X_LAST = XW'(H_DISPLAY - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_DISPLAY - 1);
    localparam logic [XW-1:0] X_LIM  = XW'(H_DISPLAY);
    localparam logic [YW-1:0] Y_LIM  = YW'(V_DISPLAY);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLIP,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [H_SIZE-1:0]     x0_q, x0_d;
    logic [V_SIZE-1:0]     y0_q, y0_d;
    logic [H_SIZE-1:0]     w_q, w_d;
    logic [V_SIZE-1:0]     h_q, h_d;
    logic [RGB_SIZE-1:0]   color_q, color_d;
    logic [XW-1:0]         x1_q, x1_d;
    logic [YW-1:0]         y1_q, y1_d;
    logic [H_SIZE-1:0]     src_x_q, src_x_d;
    logic [V_SIZE-1:0]     src_y_q, src_y_d;
    logic                  src_write_q, src_write_d;
    logic                  clip_pend_q, clip_pend_d;
    logic                  clipped_q, clipped_d;

    logic [XW-1:0]         xe, x1_c;
    logic [YW-1:0]         ye, y1_c;
    logic                  empty;
    logic                  x_at_end, y_at_end;

    // End corners carry one extra bit so x0+w overflow clamps instead of wrapping.
    always_comb begin
        xe       = {1'b0, x0_q} + {1'b0, w_q} - XW'(1);
        ye       = {1'b0, y0_q} + {1'b0, h_q} - YW'(1);
        x1_c     = (xe > X_LAST) ? X_LAST : xe;
        y1_c     = (ye > Y_LAST) ? Y_LAST : ye;
        empty    = (w_q == '0) || (h_q == '0) ||
                   ({1'b0, x0_q} >= X_LIM) || ({1'b0, y0_q} >= Y_LIM);
        x_at_end = ({1'b0, src_x_q} == x1_q);
        y_at_end = ({1'b0, src_y_q} == y1_q);
    end

    always_comb begin
        state_d     = state_q;
        x0_d        = x0_q;
        y0_d        = y0_q;
        w_d         = w_q;
        h_d         = h_q;
        color_d     = color_q;
        x1_d        = x1_q;
        y1_d        = y1_q;
        src_x_d     = src_x_q;
        src_y_d     = src_y_q;
        src_write_d = src_write_q;
        clip_pend_d = clip_pend_q;
        clipped_d   = clipped_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    x0_d    = cmd_x0;
                    y0_d    = cmd_y0;
                    w_d     = cmd_w;
                    h_d     = cmd_h;
                    color_d = cmd_color;
                    state_d = S_CLIP;
                end
            end
            S_CLIP: begin
                x1_d = x1_c;
                y1_d = y1_c;
                if (empty) begin
                    clipped_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    clip_pend_d = (xe > x1_c) || (ye > y1_c);
                    src_x_d     = x0_q;
                    src_y_d     = y0_q;
                    src_write_d = 1'b1;
                    state_d     = S_WRITE;
                end
            end
            S_WRITE: begin
                if (src_write_q && src_rdy) begin
                    if (x_at_end) begin
                        if (y_at_end) begin
                            src_write_d = 1'b0;
                            clipped_d   = clip_pend_q;
                            state_d     = S_DONE;
                        end else begin
                            src_x_d = x0_q;
                            src_y_d = src_y_q + V_SIZE'(1);
                        end
                    end else begin
                        src_x_d = src_x_q + H_SIZE'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d     = S_IDLE;
                src_write_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= S_IDLE;
            x0_q        <= '0;
            y0_q        <= '0;
            w_q         <= '0;
            h_q         <= '0;
            color_q     <= '0;
            x1_q        <= '0;
            y1_q        <= '0;
            src_x_q     <= '0;
            src_y_q     <= '0;
            src_write_q <= 1'b0;
            clip_pend_q <= 1'b0;
            clipped_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            x0_q        <= x0_d;
            y0_q        <= y0_d;
            w_q         <= w_d;
            h_q         <= h_d;
            color_q     <= color_d;
            x1_q        <= x1_d;
            y1_q        <= y1_d;
            src_x_q     <= src_x_d;
            src_y_q     <= src_y_d;
            src_write_q <= src_write_d;
            clip_pend_q <= clip_pend_d;
            clipped_q   <= clipped_d;
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign clipped   = clipped_q;
    assign src_read  = 1'b0;
    assign src_write = src_write_q;
    assign src_x     = src_x_q;
    assign src_y     = src_y_q;

    always_comb begin
        src_writedata                 = '0;
        src_writedata[RGB_SIZE-1:0]   = color_q;
    end

endmodule

// File: tb/tb_vga_rect_fill_engine.sv
// Bench for vga_rect_fill_engine: directed and random rectangles compared
// against a raster-list reference model built from plain arithmetic.
module tb_vga_rect_fill_engine;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_x0, cmd_y0, cmd_w, cmd_h;
    logic [11:0] cmd_color;
    logic        busy, done, clipped, src_read, src_write;
    logic [9:0]  src_x, src_y;
    logic [15:0] src_writedata;
    logic        src_rdy;

    int n_tests = 0;
    int n_fail  = 0;

    int exp_x[$];
    int exp_y[$];

    bit hold_next;
    int nxt_x0, nxt_y0, nxt_w, nxt_h, nxt_color;

    vga_rect_fill_engine dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_x0       (cmd_x0),
        .cmd_y0       (cmd_y0),
        .cmd_w        (cmd_w),
        .cmd_h        (cmd_h),
        .cmd_color    (cmd_color),
        .busy         (busy),
        .done         (done),
        .clipped      (clipped),
        .src_read     (src_read),
        .src_write    (src_write),
        .src_x        (src_x),
        .src_y        (src_y),
        .src_writedata(src_writedata),
        .src_rdy      (src_rdy)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference: list of visible pixels in raster order plus the clipped flag.
    task automatic build_exp(input int x0, input int y0, input int w, input int h, output bit clip);
        int xe, ye, xl, yl;
        exp_x.delete();
        exp_y.delete();
        if (w == 0 || h == 0 || x0 >= 640 || y0 >= 480) begin
            clip = 1'b1;
        end else begin
            xe   = x0 + w - 1;
            ye   = y0 + h - 1;
            clip = (xe > 639) || (ye > 479);
            xl   = (xe > 639) ? 639 : xe;
            yl   = (ye > 479) ? 479 : ye;
            for (int y = y0; y <= yl; y++)
                for (int x = x0; x <= xl; x++) begin
                    exp_x.push_back(x);
                    exp_y.push_back(y);
                end
        end
    endtask

    // rdy_mode: 0 always ready, 1 pattern 1-0-0-1, 2 random
    task automatic run_cmd(input int x0, input int y0, input int w, input int h,
                           input int color, input int rdy_mode);
        bit clip_exp, empty_exp, prev_stall, got_done;
        int k, first_k, last_k, nwr, nexp, px, py;
        bit [3:0] pat;
        pat = 4'b1001;
        build_exp(x0, y0, w, h, clip_exp);
        nexp      = exp_x.size();
        empty_exp = (nexp == 0);
        @(negedge sys_clk);
        cmd_x0    = 10'(x0);
        cmd_y0    = 10'(y0);
        cmd_w     = 10'(w);
        cmd_h     = 10'(h);
        cmd_color = 12'(color);
        cmd_valid = 1'b1;
        check_eq("cmd_ready_idle", cmd_ready, 1);
        k = 0; first_k = -1; last_k = -1; nwr = 0;
        prev_stall = 0; got_done = 0; px = 0; py = 0;
        while (k < 2000 && !got_done) begin
            @(negedge sys_clk);
            k++;
            if (k == 1) begin
                check_eq("busy_after_accept", busy, 1);
                if (hold_next) begin
                    cmd_x0    = 10'(nxt_x0);
                    cmd_y0    = 10'(nxt_y0);
                    cmd_w     = 10'(nxt_w);
                    cmd_h     = 10'(nxt_h);
                    cmd_color = 12'(nxt_color);
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            check_eq("cmd_ready_busy", cmd_ready, 0);
            if (prev_stall) begin
                check_eq("hold_write", src_write, 1);
                check_eq("hold_x", src_x, px);
                check_eq("hold_y", src_y, py);
            end
            if (done) begin
                got_done = 1;
                if (empty_exp) check_eq("empty_done_lat", k, 2);
                else           check_eq("done_lat", k - last_k, 1);
                check_eq("clipped", clipped, clip_exp);
                check_eq("write_off_at_done", src_write, 0);
                check_eq("write_count", nwr, nexp);
            end else begin
                case (rdy_mode)
                    0:       src_rdy = 1'b1;
                    1:       src_rdy = pat[k % 4];
                    default: src_rdy = 1'($urandom_range(0, 1));
                endcase
                prev_stall = 0;
                if (src_write) begin
                    if (first_k < 0) begin
                        first_k = k;
                        check_eq("first_write_lat", k, 2);
                    end
                    check_eq("wdata", src_writedata, color & 12'hFFF);
                    if (src_rdy) begin
                        if (exp_x.size() == 0) begin
                            check_eq("extra_write", 1, 0);
                        end else begin
                            check_eq("pix_x", src_x, exp_x.pop_front());
                            check_eq("pix_y", src_y, exp_y.pop_front());
                        end
                        nwr++;
                        last_k = k;
                    end else begin
                        prev_stall = 1;
                        px = int'(src_x);
                        py = int'(src_y);
                    end
                end
            end
        end
        check_eq("done_seen", got_done, 1);
    endtask

    initial begin
        int n, k;
        sys_rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_x0 = '0; cmd_y0 = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;
        src_rdy = 1'b0;
        hold_next = 0;
        nxt_x0 = 0; nxt_y0 = 0; nxt_w = 0; nxt_h = 0; nxt_color = 0;
        #12;
        check_eq("rst_cmd_ready", cmd_ready, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_clipped", clipped, 0);
        check_eq("rst_write", src_write, 0);
        check_eq("rst_x", src_x, 0);
        check_eq("rst_y", src_y, 0);
        check_eq("rst_wdata", src_writedata, 0);
        check_eq("src_read", src_read, 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;

        run_cmd(10, 20, 3, 2, 'hF00, 0);
        run_cmd(10, 20, 3, 2, 'hF00, 1);
        run_cmd(638, 479, 5, 4, 'h0AB, 0);
        run_cmd(5, 5, 0, 3, 'h123, 0);
        run_cmd(700, 5, 4, 3, 'h456, 2);
        run_cmd(1000, 470, 1000, 20, 'h789, 2);

        hold_next = 1;
        nxt_x0 = 100; nxt_y0 = 200; nxt_w = 4; nxt_h = 3; nxt_color = 'h5A5;
        run_cmd(50, 60, 5, 2, 'h3C3, 2);
        hold_next = 0;
        run_cmd(nxt_x0, nxt_y0, nxt_w, nxt_h, nxt_color, 0);

        for (int i = 0; i < 12; i++) begin
            int rx, ry;
            rx = (i % 2 == 0) ? int'($urandom_range(0, 60)) : int'($urandom_range(600, 700));
            ry = (i % 3 == 0) ? int'($urandom_range(460, 500)) : int'($urandom_range(0, 479));
            run_cmd(rx, ry, int'($urandom_range(0, 12)), int'($urandom_range(0, 6)),
                    int'($urandom_range(0, 4095)), int'($urandom_range(0, 2)));
        end

        // Reset in the middle of a 100-pixel line.
        @(negedge sys_clk);
        cmd_x0 = 10'd5; cmd_y0 = 10'd7; cmd_w = 10'd100; cmd_h = 10'd1;
        cmd_color = 12'hABC; cmd_valid = 1'b1; src_rdy = 1'b1;
        n = 0; k = 0;
        while (n < 40 && k < 200) begin
            @(negedge sys_clk);
            k++;
            if (k == 1) cmd_valid = 1'b0;
            if (src_write && src_rdy) begin
                check_eq("rst_run_x", src_x, 5 + n);
                n++;
            end
        end
        check_eq("rst_run_count", n, 40);
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        #1;
        check_eq("midrst_write", src_write, 0);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_done", done, 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge sys_clk);
            check_eq("post_rst_ready", cmd_ready, 1);
            check_eq("post_rst_nodone", done, 0);
            check_eq("post_rst_nowrite", src_write, 0);
        end

        run_cmd(630, 10, 20, 2, 'hFFF, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_rect_fill_engine.md
Name: vga_rect_fill_engine

Overview:
- Command-driven drawing master that writes solid-colour rectangles into the SDRAM frame buffer through its memory-mapped source port (src_write/src_x/src_y/src_writedata/src_rdy).
- Sits between the pixel-generation control logic and the frame buffer, entirely in the sys_clk domain.
- Accepts one rectangle command at a time, clips it to the visible area and issues one write per pixel in raster order, stalling on src_rdy.

Parameters:
- H_SIZE, 10, width of x coordinates and widths.
- V_SIZE, 10, width of y coordinates and heights.
- H_DISPLAY, 640, visible pixels per line.
- V_DISPLAY, 480, visible lines per frame.
- RGB_SIZE, 12, colour width.
- AVS_DW, 16, source data width; must be >= RGB_SIZE.

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  reset, asynchronous assert, active-low.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  engine can accept a command.
- cmd_x0  in  H_SIZE  rectangle left x.
- cmd_y0  in  V_SIZE  rectangle top y.
- cmd_w  in  H_SIZE  width in pixels.
- cmd_h  in  V_SIZE  height in lines.
- cmd_color  in  RGB_SIZE  fill colour.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse when a command retires.
- clipped  out  1  the last command was clipped or empty; valid with done and held until the next done.
- src_read  out  1  tied 0.
- src_write  out  1  write request.
- src_x  out  H_SIZE  pixel x.
- src_y  out  V_SIZE  pixel y.
- src_writedata  out  AVS_DW  colour zero-extended to AVS_DW.
- src_rdy  in  1  frame buffer accepts a write this cycle.

Behaviour:
- Reset values (sys_rst_n low, asynchronous): state IDLE, cmd_ready=1, busy=0, done=0, clipped=0, src_write=0, src_x=0, src_y=0, src_writedata=0. A reset mid-command abandons it immediately; no further writes are issued and done is not generated.
- States: IDLE, CLIP, WRITE, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid & cmd_ready, register x0, y0, w, h and colour, then go to CLIP.
  - busy=1 from the next cycle.
- CLIP (1 cycle):
  - Compute xe = x0+w-1 in H_SIZE+1 bits and ye = y0+h-1 in V_SIZE+1 bits.
  - Clamp: x1 = min(xe, H_DISPLAY-1), y1 = min(ye, V_DISPLAY-1).
  - Empty if w==0, h==0, x0>=H_DISPLAY or y0>=V_DISPLAY. Empty goes to DONE with clipped=1 and zero writes.
  - Otherwise clipped = (xe>x1)|(ye>y1). Load src_x=x0, src_y=y0, assert src_write and go to WRITE.
- WRITE:
  - src_write, src_x, src_y and src_writedata are registered outputs. They are held stable until the cycle src_write & src_rdy is high; that cycle is the transfer.
  - src_write never depends combinationally on src_rdy.
  - On transfer, if src_x==x1:
    - If src_y==y1: deassert src_write next cycle and go to DONE.
    - Otherwise src_x<=x0 and src_y<=src_y+1.
  - On transfer when src_x!=x1: src_x<=src_x+1.
  - Back-to-back transfers are allowed: one pixel per cycle while src_rdy is held high.
- DONE (1 cycle): done=1, busy=0 next cycle, return to IDLE with cmd_ready=1 next cycle.
- Latency:
  - Command accept to first src_write: 2 cycles.
  - Last transfer to done: 1 cycle.
  - Pixel count = (x1-x0+1)*(y1-y0+1).
- Simultaneous events:
  - cmd_valid during busy is ignored (cmd_ready=0) and must be held by the master.
  - A new command can be accepted in the cycle after done.
- Arithmetic: no wrap-around is permitted. Overflow of x0+w is captured in the extra bit and handled by clamping.

Test Plan:
- Basic fill: cmd x0=10, y0=20, w=3, h=2, color=0xF00, src_rdy=1 always -> exactly 6 writes (10,20), (11,20), (12,20), (10,21), (11,21), (12,21), data 0x0F00, done 1 cycle after the last write, clipped=0.
- Backpressure: same command, src_rdy toggling 1-0-0-1 -> outputs held stable while src_rdy=0, the same 6 transfers in order, no duplicates or drops.
- Clipping: x0=638, y0=479, w=5, h=4 -> writes (638,479) and (639,479) only, clipped=1.
- Empty: w=0, or x0=700 -> zero writes, done 2 cycles after accept, clipped=1.
- Reset mid-op: 1x100 fill, sys_rst_n low after 40 writes -> src_write=0 immediately, busy=0, cmd_ready=1 after release, no done.
- Command during busy: second cmd_valid held during a fill -> accepted the cycle after done, executes fully.
